// File: rtl/maxmin_pkg.sv
// Shared types and constants for the max-min streaming reduction.
package maxmin_pkg;

    localparam int unsigned W_DEFAULT  = 16;
    localparam int unsigned BEAT_LANES = 4;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // All-ones value of the requested width (min identity), right-aligned in 64 bits.
    function automatic logic [63:0] all_ones(input int unsigned w);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < w) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Beat counter increment that sticks at its maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/maxmin_lane4.sv
// Combinational beat reduction: r = min(acc, max(a0,b0), ..., max(a3,b3)).
module maxmin_lane4
    import maxmin_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [BEAT_LANES*W-1:0] a_i,
    input  logic [BEAT_LANES*W-1:0] b_i,
    input  logic [W-1:0]            acc_i,
    output logic [W-1:0]            r_o
);

    // Lane maxima folded into a running minimum seeded by the accumulator.
    always_comb begin
        logic [W-1:0] m;
        m   = '0;
        r_o = acc_i;
        for (int unsigned i = 0; i < BEAT_LANES; i++) begin
            m = (a_i[i*W +: W] > b_i[i*W +: W]) ? a_i[i*W +: W] : b_i[i*W +: W];
            if (m < r_o) begin
                r_o = m;
            end
        end
    end

endmodule

// File: rtl/maxmin_reduce_stream.sv
// Streaming max-min reduction: folds 4-pair beats into an accumulator and
// presents one result per vector over a valid/ready handshake.
module maxmin_reduce_stream
    import maxmin_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [BEAT_LANES*W-1:0] in_a,
    input  logic [BEAT_LANES*W-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic [CNT_W-1:0]        out_beats
);

    localparam logic [W-1:0] IDENT = W'(all_ones(W));

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;
    logic [W-1:0]     beat_r;
    logic             accept;

    maxmin_lane4 #(.W(W)) u_lane4 (
        .a_i   (in_a),
        .b_i   (in_b),
        .acc_i (acc_q),
        .r_o   (beat_r)
    );

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave ACCUM on an accepted last beat, leave HOLD when consumed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (accept && in_last) state_d = HOLD;
            HOLD:  if (out_ready)         state_d = ACCUM;
            default:                      state_d = ACCUM;
        endcase
    end

    // Handshake outputs decoded purely from registered state.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    // Datapath next values: fold accepted beats, capture result on the last one.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        if (accept) begin
            if (in_last) begin
                out_data_d  = beat_r;
                out_beats_d = sat_inc(cnt_q);
                acc_d       = IDENT;
                cnt_d       = '0;
            end else begin
                acc_d = beat_r;
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    // Accumulator, beat counter and output holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= IDENT;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_maxmin_reduce_stream.sv
// Scoreboard bench for maxmin_reduce_stream with a plain-arithmetic reference.
module tb_maxmin_reduce_stream;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [63:0]   in_a = '0;
    logic [63:0]   in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   out_data;
    logic [15:0]   out_beats;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] data;
        logic [15:0] beats;
    } exp_t;
    exp_t sb[$];

    bit rand_ready  = 1'b0;
    bit force_ready = 1'b1;

    // reference state for the vector being issued
    logic [15:0] mdl_min = 16'hFFFF;
    int          mdl_n   = 0;

    maxmin_reduce_stream #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic model_clear();
        mdl_min = 16'hFFFF;
        mdl_n   = 0;
    endtask

    // Build lane operands whose per-lane maximum equals the given value.
    task automatic make_lanes(input logic [63:0] maxes, output logic [63:0] a, output logic [63:0] b);
        logic [15:0] mx, other;
        a = '0;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            mx    = maxes[i*16 +: 16];
            other = 16'($urandom_range(0, int'(mx)));
            if ($urandom_range(0, 1) == 0) begin
                a[i*16 +: 16] = mx;
                b[i*16 +: 16] = other;
            end else begin
                a[i*16 +: 16] = other;
                b[i*16 +: 16] = mx;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input bit last);
        int guard;
        logic [15:0] x, y, m;
        for (int i = 0; i < 4; i++) begin
            x = a[i*16 +: 16];
            y = b[i*16 +: 16];
            m = (x > y) ? x : y;
            if (m < mdl_min) mdl_min = m;
        end
        mdl_n++;
        if (last) begin
            sb.push_back('{mdl_min, (mdl_n > 65535) ? 16'hFFFF : 16'(mdl_n)});
            model_clear();
        end
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                check("in_ready_timeout", 32'(in_ready), 32'd1);
                finish_up();
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) begin
            check("latency_out_valid", 32'(out_valid), 32'd1);
            check("latency_in_ready", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic bubbles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_a    = {$urandom, $urandom};
            in_b    = {$urandom, $urandom};
            in_last = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_last = 1'b0;
    endtask

    task automatic send_maxes(input logic [63:0] maxes, input bit last);
        logic [63:0] a, b;
        make_lanes(maxes, a, b);
        send_beat(a, b, last);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: owns out_ready, pops the scoreboard on each output handshake.
    initial begin : monitor
        exp_t        e;
        bit          held;
        logic [15:0] hd, hb;
        held = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                check("ready_valid_exclusive", 32'(in_ready), 32'(!out_valid));
                if (held) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(hd));
                    check("hold_beats", 32'(out_beats), 32'(hb));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_beats", 32'(out_beats), 32'(e.beats));
                    end
                    held = 1'b0;
                end else if (out_valid) begin
                    held = 1'b1;
                    hd   = out_data;
                    hb   = out_beats;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin : stimulus
        logic [63:0] a, b;
        int n;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_beats", 32'(out_beats), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single-beat vector from the plan: maxes 5,2,7,4 -> 2
        a = {16'd4, 16'd3, 16'd2, 16'd1};
        b = {16'd1, 16'd7, 16'd0, 16'd5};
        send_beat(a, b, 1'b1);
        bubbles(2);

        // three-beat vector with bubbles -> 3
        send_maxes({16'd20, 16'd11, 16'd12, 16'd10}, 1'b0);
        bubbles(3);
        send_maxes({16'd9, 16'd9, 16'd9, 16'd3}, 1'b0);
        bubbles(1);
        send_maxes({16'd8, 16'd8, 16'd8, 16'd8}, 1'b1);
        bubbles(2);

        // backpressure: result held while inputs toggle
        force_ready = 1'b0;
        @(negedge clk);
        send_maxes({16'd100, 16'd200, 16'd300, 16'd77}, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = {$urandom, $urandom};
            in_b     = {$urandom, $urandom};
            in_last  = 1'($urandom_range(0, 1));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", 32'(out_data), 32'd77);
            @(negedge clk);
        end
        in_valid    = 1'b0;
        in_last     = 1'b0;
        force_ready = 1'b1;
        bubbles(2);
        send_maxes({16'd43, 16'd42, 16'd41, 16'd40}, 1'b1);
        bubbles(2);

        // identity then zeros
        send_beat('1, '1, 1'b1);
        bubbles(1);
        send_beat('0, '0, 1'b1);
        bubbles(2);
        drain();

        // async reset mid-vector (acc=5 after two beats)
        send_maxes({16'd9, 16'd8, 16'd6, 16'd7}, 1'b0);
        send_maxes({16'd5, 16'd12, 16'd10, 16'd5}, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_beats", 32'(out_beats), 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        send_maxes({16'd9, 16'd9, 16'd9, 16'd9}, 1'b1);
        bubbles(2);
        drain();

        // randomized vectors with random consumer backpressure
        rand_ready = 1'b1;
        for (int v = 0; v < 40; v++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a = {$urandom, $urandom} & 64'h00FF_00FF_00FF_00FF;
                    b = {$urandom, $urandom} & 64'h00FF_00FF_00FF_00FF;
                end else begin
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                end
                send_beat(a, b, k == n - 1);
                bubbles($urandom_range(0, 2));
            end
        end
        rand_ready  = 1'b0;
        force_ready = 1'b1;
        drain();

        // beat-count saturation: 70000 beats then last
        for (int k = 0; k < 70000; k++) begin
            a = {$urandom, $urandom} | 64'h0100_0100_0100_0100;
            b = {$urandom, $urandom};
            send_beat(a, b, 1'b0);
        end
        send_maxes({16'd600, 16'd300, 16'd500, 16'd400}, 1'b1);
        bubbles(2);
        drain();

        finish_up();
    end

    // Absolute time guard so the run always ends.
    initial begin : watchdog
        #5_000_000;
        check("global_timeout", 32'd1, 32'd0);
        finish_up();
    end

endmodule
